// File: rtl/axil_master_bridge.sv
// Single-outstanding bridge from a valid/ready command port to an AXI4-Lite master.
// Commands are accepted only in IDLE; one response is returned per command.
module axil_master_bridge #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                        AWVALID,
  output logic [2:0]                  AWPROT,
  input  logic                        AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  output logic                        ARVALID,
  output logic [2:0]                  ARPROT,
  input  logic                        ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                  RRESP,
  input  logic                        RVALID,
  output logic                        RREADY
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRITE_RESP,
    S_READ_ADDR,
    S_READ_DATA,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      aw_hs, w_hs;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    aw_hs       = awvalid_q & AWREADY;
    w_hs        = wvalid_q & WREADY;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_READ_ADDR;
          end
        end
      end
      S_WRITE: begin
        // AW and W complete independently; leave only when both have been seen
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = S_WRITE_RESP;
        end
      end
      S_WRITE_RESP: begin
        if (BVALID) begin
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          state_d     = S_RESP;
        end
      end
      S_READ_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_READ_DATA;
        end
      end
      S_READ_DATA: begin
        if (RVALID) begin
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = addr_q;
  assign AWVALID   = awvalid_q;
  assign AWPROT    = 3'b000;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = (state_q == S_WRITE_RESP);
  assign ARADDR    = addr_q;
  assign ARVALID   = arvalid_q;
  assign ARPROT    = 3'b000;
  assign RREADY    = (state_q == S_READ_DATA);

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge: the slave side is driven by hand, cycle by cycle.
module tb_axil_master_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, ARVALID, ARREADY;
  logic [2:0]  AWPROT, ARPROT;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, RVALID, RREADY;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axil_master_bridge #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
    BVALID = 1'b0; BRESP = 2'b00; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;

    // Reset state
    tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", AWVALID, 0);
    check("rst_wvalid", WVALID, 0);
    check("rst_arvalid", ARVALID, 0);
    check("rst_bready", BREADY, 0);
    check("rst_rready", RREADY, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_awaddr", AWADDR, 0);
    check("rst_wdata", WDATA, 0);
    check("rst_wstrb", WSTRB, 0);
    check("prot", {AWPROT, ARPROT}, 0);
    reset = 1'b0;
    #1;
    check("idle_cmd_ready", cmd_ready, 1);

    // 1: write, all READYs high, minimum latency
    AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
    send_cmd(1'b1, 4'h4, 32'h12345678, 4'hF);
    tick();
    cmd_valid = 1'b0;
    check("w1_awvalid", AWVALID, 1);
    check("w1_wvalid", WVALID, 1);
    check("w1_awaddr", AWADDR, 4'h4);
    check("w1_wdata", WDATA, 32'h12345678);
    check("w1_wstrb", WSTRB, 4'hF);
    check("w1_cmd_ready", cmd_ready, 0);
    check("w1_bready_early", BREADY, 0);
    tick();
    check("w1_awvalid_drop", AWVALID, 0);
    check("w1_wvalid_drop", WVALID, 0);
    check("w1_bready", BREADY, 1);
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    check("w1_rsp_valid", rsp_valid, 1);
    check("w1_rsp_resp", rsp_resp, 0);
    check("w1_rsp_rdata", rsp_rdata, 0);
    check("w1_bready_after", BREADY, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("w1_rsp_done", rsp_valid, 0);
    check("w1_cmd_ready_back", cmd_ready, 1);

    // 2: AWREADY delayed 3 cycles, WREADY immediate
    AWREADY = 1'b0;
    send_cmd(1'b1, 4'hC, 32'hA5A50F0F, 4'h3);
    tick();
    cmd_valid = 1'b0;
    check("w2_awvalid_c1", AWVALID, 1);
    check("w2_wvalid_c1", WVALID, 1);
    tick();
    check("w2_wvalid_drop", WVALID, 0);
    check("w2_awvalid_c2", AWVALID, 1);
    check("w2_awaddr_c2", AWADDR, 4'hC);
    check("w2_bready_c2", BREADY, 0);
    tick();
    check("w2_awvalid_c3", AWVALID, 1);
    check("w2_awaddr_c3", AWADDR, 4'hC);
    check("w2_bready_c3", BREADY, 0);
    AWREADY = 1'b1;
    tick();
    check("w2_awvalid_drop", AWVALID, 0);
    check("w2_bready", BREADY, 1);
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    check("w2_rsp_valid", rsp_valid, 1);
    check("w2_rsp_resp", rsp_resp, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("w2_rsp_done", rsp_valid, 0);
    tick();
    check("w2_single_rsp", rsp_valid, 0);
    check("w2_no_aw", AWVALID, 0);

    // 3: read with two wait cycles on R
    send_cmd(1'b0, 4'h8, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    check("r3_arvalid", ARVALID, 1);
    check("r3_araddr", ARADDR, 4'h8);
    check("r3_rready_early", RREADY, 0);
    check("r3_no_aw", AWVALID, 0);
    tick();
    check("r3_arvalid_drop", ARVALID, 0);
    check("r3_rready", RREADY, 1);
    tick();
    check("r3_rready_wait1", RREADY, 1);
    tick();
    check("r3_rready_wait2", RREADY, 1);
    RVALID = 1'b1; RDATA = 32'hDEADBEEF; RRESP = 2'b00;
    tick();
    RVALID = 1'b0; RDATA = '0;
    check("r3_rsp_valid", rsp_valid, 1);
    check("r3_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("r3_rsp_resp", rsp_resp, 0);
    check("r3_rready_after", RREADY, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 4: read returning SLVERR, passed through without retry
    send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    RVALID = 1'b1; RDATA = 32'h0BADF00D; RRESP = 2'b10;
    tick();
    RVALID = 1'b0; RRESP = 2'b00;
    check("r4_rsp_resp", rsp_resp, 2'b10);
    check("r4_rsp_rdata", rsp_rdata, 32'h0BADF00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("r4_idle", cmd_ready, 1);
    check("r4_no_retry", ARVALID, 0);

    // 5: write then read back-to-back, response stalled for 5 cycles
    send_cmd(1'b1, 4'h4, 32'h11112222, 4'hF);
    tick();
    cmd_write = 1'b0; cmd_addr = 4'h8;
    check("b5_busy", cmd_ready, 0);
    tick();
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    check("b5_wr_rdata_zero", rsp_rdata, 0);
    for (int i = 0; i < 5; i++) begin
      check("b5_stall_cmd_ready", cmd_ready, 0);
      check("b5_stall_arvalid", ARVALID, 0);
      check("b5_stall_rsp_valid", rsp_valid, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("b5_cmd_ready_back", cmd_ready, 1);
    check("b5_no_ar_yet", ARVALID, 0);
    tick();
    cmd_valid = 1'b0;
    check("b5_arvalid", ARVALID, 1);
    check("b5_araddr", ARADDR, 4'h8);
    tick();
    RVALID = 1'b1; RDATA = 32'h00000055; RRESP = 2'b00;
    tick();
    RVALID = 1'b0;
    check("b5_rsp_rdata", rsp_rdata, 32'h55);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 6: reset while AW/W are waiting for READY
    AWREADY = 1'b0; WREADY = 1'b0;
    send_cmd(1'b1, 4'hC, 32'h77778888, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("x6_awvalid_wait", AWVALID, 1);
    check("x6_wvalid_wait", WVALID, 1);
    reset = 1'b1;
    tick();
    check("x6_awvalid_rst", AWVALID, 0);
    check("x6_wvalid_rst", WVALID, 0);
    check("x6_cmd_ready_rst", cmd_ready, 0);
    check("x6_bready_rst", BREADY, 0);
    reset = 1'b0;
    #1;
    check("x6_cmd_ready_after", cmd_ready, 1);
    AWREADY = 1'b1; WREADY = 1'b1;
    send_cmd(1'b1, 4'h8, 32'hCAFEF00D, 4'hC);
    tick();
    cmd_valid = 1'b0;
    check("x6_awaddr", AWADDR, 4'h8);
    check("x6_wdata", WDATA, 32'hCAFEF00D);
    check("x6_wstrb", WSTRB, 4'hC);
    tick();
    check("x6_bready", BREADY, 1);
    BVALID = 1'b1; BRESP = 2'b11;
    tick();
    BVALID = 1'b0;
    check("x6_rsp_valid", rsp_valid, 1);
    check("x6_rsp_resp", rsp_resp, 2'b11);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("x6_idle", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- Converts single-beat requests from a simple valid/ready command port into AXI4-Lite master transactions on the five AXI-Lite channels.
- Returns read data and response through a valid/ready response port.
- Sits between the rv32im_zbb core's load/store path (or a bench sequencer) and any AXI-Lite slave. Drives the initiator side of the team's axi_lite_if signal set.
- One transaction outstanding at a time.

Parameters:
- AXI_DATA_WIDTH, 32, data bus width; multiple of 8.
- AXI_ADDR_WIDTH, 4, address bus width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  AXI_DATA_WIDTH/8  byte strobes for writes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP/RRESP.
- AWADDR, AWVALID, AWPROT  out  AXI_ADDR_WIDTH, 1, 3  write address channel.
- AWREADY  in  1.
- WDATA, WSTRB, WVALID  out  AXI_DATA_WIDTH, AXI_DATA_WIDTH/8, 1  write data channel.
- WREADY  in  1.
- BRESP  in  2.
- BVALID  in  1.
- BREADY  out  1.
- ARADDR, ARVALID, ARPROT  out  AXI_ADDR_WIDTH, 1, 3  read address channel.
- ARREADY  in  1.
- RDATA  in  AXI_DATA_WIDTH.
- RRESP  in  2.
- RVALID  in  1.
- RREADY  out  1.

Behaviour:
- Reset values (apply on the first clk edge with reset=1):
  - Outputs: all VALID/READY outputs 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, AWADDR/ARADDR/WDATA/WSTRB 0.
  - State: IDLE.
  - cmd_ready is 0 while reset=1.
- AWPROT = ARPROT = 3'b000 always.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr/wdata/wstrb; go to WRITE if cmd_write, else READ_ADDR.
  - WRITE: AWVALID and WVALID both rise the cycle after accept. Each is held until its own handshake (VALID&READY on a rising edge), then dropped next cycle. Handshakes may complete in either order or the same cycle; track them with aw_done and w_done flags. Once both are done, go to WRITE_RESP.
  - WRITE_RESP: BREADY=1. On BVALID, capture BRESP into rsp_resp, set rsp_rdata=0, go to RESP.
  - READ_ADDR: ARVALID=1 until ARREADY, then go to READ_DATA.
  - READ_DATA: RREADY=1. On RVALID, capture RDATA/RRESP, go to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_resp stable. On rsp_ready, go to IDLE; cmd_ready reasserts the next cycle.
- No command is accepted outside IDLE, so there is never more than one transaction outstanding.
- AXI rules:
  - VALID never depends combinationally on READY.
  - Address, data and strobe outputs are stable while their VALID is high.
  - BREADY/RREADY are never asserted outside their states.
- Minimum latency, with all READYs high and the slave responding in the next cycle:
  - Write: cmd accept at cycle 0, AW/W handshake at 1, B handshake at 2, rsp_valid at 3.
  - Read: cmd accept at cycle 0, AR at 1, R at 2, rsp_valid at 3.
- SLVERR/DECERR are passed through unchanged in rsp_resp; the bridge takes no other action on them.
- rsp_ready held low: the bridge stalls in RESP indefinitely; no new AXI activity.
- Reset mid-transaction: return to IDLE on the next edge with reset=1 and drop all VALID/READY outputs. The system guarantees the slave is reset simultaneously.

Test Plan:
- Write addr 0x4, wdata 0x12345678, wstrb 0xF, slave READYs always 1, BRESP=00 -> one AW/W handshake at cycle 1 with exactly those values; rsp_valid at cycle 3, rsp_resp=00, rsp_rdata=0.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle; AWVALID held 3 cycles with AWADDR stable; BREADY rises only after AW completes; exactly one response.
- Read addr 0x8, slave returns RDATA=0xDEADBEEF, RRESP=00 after 2 wait cycles -> RREADY held through the wait; rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Read with RRESP=2'b10 -> rsp_resp=2'b10; no retry; bridge returns to IDLE after rsp_ready.
- Back-to-back commands (write then read), cmd_valid held high, rsp_ready low for 5 cycles -> second command not accepted (cmd_ready=0) until the cycle after rsp_ready; no AR activity during the stall.
- reset=1 while AWVALID is high awaiting AWREADY -> next edge: AWVALID=0, WVALID=0, cmd_ready=0. After reset deasserts, cmd_ready=1 and a new write completes normally.
